rst_req: RTL
============

Name: rst_req

Overview:
- Reset-request conditioner feeding the active-low reset input of the clock/reset generator.
- Merges three reset sources into one clean active-low request of guaranteed minimum width:
  - mechanical push button (asynchronous, bouncing)
  - software reset strobe
  - watchdog timer
- Runs on the raw 50 MHz board clock, so it works before the PLL locks.
- Latches which source caused the last reset, for software to read after restart.

Parameters:
- DEB_CYCLES, 1000000, cycles a button level must be stable before it is accepted (20 ms at 50 MHz); minimum 2.
- PULSE_CYCLES, 50000, minimum low time of rst_req_n in cycles (1 ms); minimum 2.
- WDOG_CYCLES, 67108864, watchdog timeout in cycles (~1.34 s); minimum 2.

Ports:
- clk_in  input  1  board clock, 50 MHz
- rst_in_n  input  1  asynchronous active-low reset (configuration / power-on)
- btn_raw_n  input  1  raw push button, active-low, asynchronous to clk_in
- sw_rst_req  input  1  one-cycle software reset strobe, synchronous to clk_in
- wdog_en  input  1  watchdog enable, synchronous
- wdog_kick  input  1  watchdog restart strobe, synchronous
- rst_req_n  output  1  conditioned reset request, active-low, registered
- btn_db_n  output  1  debounced button level, active-low
- cause  output  3  latched reset cause: bit0 button, bit1 software, bit2 watchdog; 000 = power-on

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low on rst_in_n. No other asynchronous resets.
- Reset values:
  - state=PULSE, pulse counter=0
  - rst_req_n=0, btn_db_n=1, cause=000
  - synchronizer flops=1, all other counters=0
- Hence every release of rst_in_n produces a full power-on pulse of PULSE_CYCLES.

Button path:
- btn_raw_n passes through a two-flop synchronizer.
- Debounce counter increments while the synced level differs from btn_db_n and clears whenever they match.
- On the cycle the counter equals DEB_CYCLES-1 with the level still differing: btn_db_n takes the synced level and the counter clears.
- A glitch shorter than DEB_CYCLES cycles never changes btn_db_n.
- Total latency from raw edge to btn_db_n change is DEB_CYCLES+2 cycles.
- press event = one-cycle strobe on the btn_db_n 1->0 transition.

Watchdog:
- wdog_en=0: counter held at 0.
- wdog_en=1: counter increments each cycle; wdog_kick clears it (kick wins over increment).
- expiry event = counter equals WDOG_CYCLES-1 with no kick in the same cycle.
- The counter is also cleared while state != IDLE.

FSM (encoding from package):
- IDLE: rst_req_n=1.
  - If any of press, sw_rst_req or expiry is present: go to PULSE, clear the pulse counter, and load cause with the OR of all events present that cycle (simultaneous events set multiple bits).
- PULSE: rst_req_n=0; pulse counter increments.
  - At PULSE_CYCLES-1, go to HOLD.
  - Exactly PULSE_CYCLES low cycles when the button is not held.
- HOLD: rst_req_n=0 while btn_db_n=0 (button still held). When btn_db_n=1, go to IDLE; rst_req_n returns to 1 on entry to IDLE.
- Events arriving in PULSE or HOLD are ignored and do not alter cause.
- A re-press is only possible after a debounced release, so one press yields one pulse.
- rst_req_n is a direct flop output; latency from event to rst_req_n=0 is 1 cycle.
- cause is stable from the PULSE entry cycle until the next IDLE->PULSE transition.
- rst_in_n asserted mid-operation returns all state to the reset values immediately.

Arithmetic:
- Each counter is $clog2(its parameter) bits wide.
- Comparisons are against parameter-1, so counters never wrap.

Decomposition:
- Package rst_req_pkg holds:
  - state encoding (IDLE, PULSE, HOLD; 2 bits)
  - cause bit indices CAUSE_BTN=0, CAUSE_SW=1, CAUSE_WDOG=2
- Sub-module btn_debounce, parameterised by DEB_CYCLES, contains the synchronizer, debounce counter and press strobe. It is reusable for the board keys.

Test Plan (DEB_CYCLES=4, PULSE_CYCLES=8, WDOG_CYCLES=16):
- Power-on: release rst_in_n at cycle 0 -> rst_req_n=0 for cycles 0..7, 1 from cycle 8; cause=000; btn_db_n=1.
- Bounce: btn_raw_n low for 3 cycles, high, then low for 10 cycles -> no change from the 3-cycle glitch; btn_db_n=0 exactly 6 cycles after the final falling edge; rst_req_n=0 one cycle later; cause=001.
- Long press: hold the button 40 cycles after a press -> rst_req_n stays 0 through HOLD until 1 cycle after btn_db_n returns to 1; exactly one pulse.
- Software strobe: sw_rst_req=1 for one cycle in IDLE -> 8-cycle low pulse; cause=010. A second strobe during PULSE is ignored: pulse not extended, cause unchanged.
- Watchdog: wdog_en=1 with kicks every 10 cycles -> no reset. Kicks stopped -> expiry on the 16th cycle after the last kick; pulse follows with cause=100.
- Simultaneous events: sw_rst_req and expiry in the same IDLE cycle -> cause=110. Asserting rst_in_n mid-PULSE -> rst_req_n=0 and cause=000 immediately; a full 8-cycle pulse follows release.

Source files
------------

// File: rtl/rst_req_pkg.sv
// Shared definitions for the reset-request conditioner: FSM encoding and
// bit positions of the latched reset cause.
package rst_req_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int CAUSE_W    = 3;
    localparam int CAUSE_BTN  = 0;
    localparam int CAUSE_SW   = 1;
    localparam int CAUSE_WDOG = 2;

endpackage

// File: rtl/rst_req_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle press strobe on the debounced 1->0 transition.
module btn_debounce
    import rst_req_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_raw_n_i,
    output logic btn_db_n_o,
    output logic press_o
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Registered so the strobe coincides with the cycle btn_db_n reads 0.
        press_d = db_q & ~db_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_n_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db_n_o = db_q;
    assign press_o    = press_q;

endmodule

// File: rtl/rst_req.sv
// Reset-request conditioner: merges button, software strobe and watchdog into
// one registered active-low request of guaranteed width and latches its cause.
module rst_req
    import rst_req_pkg::*;
#(
    parameter int DEB_CYCLES   = 1000000,
    parameter int PULSE_CYCLES = 50000,
    parameter int WDOG_CYCLES  = 67108864
) (
    input  logic               clk_in,
    input  logic               rst_in_n,
    input  logic               btn_raw_n,
    input  logic               sw_rst_req,
    input  logic               wdog_en,
    input  logic               wdog_kick,
    output logic               rst_req_n,
    output logic               btn_db_n,
    output logic [CAUSE_W-1:0] cause
);

    localparam int              PC_W    = $clog2(PULSE_CYCLES);
    localparam int              WD_W    = $clog2(WDOG_CYCLES);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PULSE_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pcnt_q, pcnt_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [CAUSE_W-1:0]   cause_q, cause_d;
    logic                 rst_req_n_q, rst_req_n_d;
    logic                 press, expiry;
    logic [CAUSE_W-1:0]   events;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn (
        .clk_i       (clk_in),
        .rst_n_i     (rst_in_n),
        .btn_raw_n_i (btn_raw_n),
        .btn_db_n_o  (btn_db_n),
        .press_o     (press)
    );

    always_comb begin
        expiry             = wdog_en && (wd_q == WD_LAST) && !wdog_kick;
        events             = '0;
        events[CAUSE_BTN]  = press;
        events[CAUSE_SW]   = sw_rst_req;
        events[CAUSE_WDOG] = expiry;

        state_d = state_q;
        pcnt_d  = pcnt_q;
        cause_d = cause_q;

        if ((state_q != IDLE) || !wdog_en || wdog_kick || expiry) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + WD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (|events) begin
                    state_d = PULSE;
                    pcnt_d  = '0;
                    cause_d = events;
                end
            end
            PULSE: begin
                pcnt_d = pcnt_q + PC_W'(1);
                if (pcnt_q == PC_LAST) begin
                    pcnt_d = '0;
                    // Skip HOLD when the button is already released so the
                    // pulse is exactly PULSE_CYCLES long.
                    state_d = btn_db_n ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (btn_db_n) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rst_req_n_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= PULSE;
            pcnt_q      <= '0;
            wd_q        <= '0;
            cause_q     <= '0;
            rst_req_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            wd_q        <= wd_d;
            cause_q     <= cause_d;
            rst_req_n_q <= rst_req_n_d;
        end
    end

    assign rst_req_n = rst_req_n_q;
    assign cause     = cause_q;

endmodule
